// File: rtl/add_image_hls_deadlock_report_unit_if.sv
// Signal bundle between the deadlock report unit, the detect units and the
// report consumer. The report unit is the master of the report stream.
interface add_image_hls_deadlock_report_unit_if #(
  parameter int PROC_NUM  = 4,
  parameter int CHAN_NUM  = 8,
  parameter int PROC_ID_W = 2,
  parameter int CHAN_ID_W = 3
) ();
  logic [PROC_NUM-1:0]  dl_detect_vec;
  logic [CHAN_NUM-1:0]  token_vec;
  logic                 dl_detect_in;
  logic [PROC_NUM-1:0]  origin_vec;
  logic                 token_clear;
  logic                 report_valid;
  logic                 report_ready;
  logic [PROC_ID_W-1:0] report_proc_id;
  logic [CHAN_ID_W-1:0] report_chan_id;
  logic                 report_last;
  logic                 report_error;
  logic                 deadlock_found;

  modport master (
    input  dl_detect_vec, token_vec, report_ready,
    output dl_detect_in, origin_vec, token_clear, report_valid,
           report_proc_id, report_chan_id, report_last, report_error,
           deadlock_found
  );

  modport slave (
    output dl_detect_vec, token_vec, report_ready,
    input  dl_detect_in, origin_vec, token_clear, report_valid,
           report_proc_id, report_chan_id, report_last, report_error,
           deadlock_found
  );
endinterface

// File: rtl/add_image_hls_deadlock_report_unit.sv
// Arbitrates the first deadlock, traces the token around the wait-for cycle,
// records each crossed channel and streams the path out as a report.
module add_image_hls_deadlock_report_unit #(
  parameter int PROC_NUM  = 4,
  parameter int CHAN_NUM  = 8,
  parameter int PROC_ID_W = 2,
  parameter int CHAN_ID_W = 3
) (
  input logic clock,
  input logic reset,
  add_image_hls_deadlock_report_unit_if.master bus
);
  localparam int TIMEOUT = CHAN_NUM + 4;
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = $clog2(CHAN_NUM + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_TRACE  = 3'd2,
    S_CLEAR  = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [CHAN_ID_W-1:0] lowest_chan(input logic [CHAN_NUM-1:0] v);
    logic [CHAN_ID_W-1:0] idx;
    idx = '0;
    for (int i = CHAN_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = CHAN_ID_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [PROC_ID_W-1:0] lowest_proc(input logic [PROC_NUM-1:0] v);
    logic [PROC_ID_W-1:0] idx;
    idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = PROC_ID_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [CHAN_ID_W-1:0] ptr_inc(input logic [CHAN_ID_W-1:0] p);
    return (p == CHAN_ID_W'(CHAN_NUM - 1)) ? '0 : p + CHAN_ID_W'(1);
  endfunction

  state_t               r_state, w_state_nxt;
  logic [PROC_ID_W-1:0] r_origin, w_origin_nxt;
  logic                 r_dl_detect_in, w_dl_detect_in_nxt;
  logic                 r_found, w_found_nxt;
  logic [PROC_NUM-1:0]  r_origin_vec, w_origin_vec_nxt;
  logic                 r_token_clear, w_token_clear_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_last, w_last_nxt;
  logic                 r_error, w_error_nxt;
  logic [PROC_ID_W-1:0] r_proc_id, w_proc_id_nxt;
  logic [CHAN_ID_W-1:0] r_chan_id, w_chan_id_nxt;
  logic [TO_W-1:0]      r_timeout, w_timeout_nxt;
  logic                 r_pushed, w_pushed_nxt;
  logic                 r_zero_seen, w_zero_seen_nxt;
  logic                 w_push, w_load, w_fifo_clr, w_return, w_abort;
  logic [CHAN_ID_W-1:0] w_token_idx, w_det_idx_ext, w_head;
  logic [PROC_ID_W-1:0] w_det_idx;

  logic [CHAN_ID_W-1:0] r_fifo [CHAN_NUM];
  logic [CHAN_ID_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  assign w_token_idx   = lowest_chan(bus.token_vec);
  assign w_det_idx     = lowest_proc(bus.dl_detect_vec);
  assign w_det_idx_ext = '0;
  assign w_head        = r_fifo[r_rd_ptr];
  assign w_return      = bus.dl_detect_vec[r_origin];
  // Lost token: two consecutive empty cycles once the path has started.
  assign w_abort       = ((bus.token_vec == '0) && r_pushed && r_zero_seen) ||
                         (r_timeout == TO_W'(TIMEOUT - 1));

  // Next-state and next-output computation for the trace/report sequencer.
  always_comb begin
    w_state_nxt        = r_state;
    w_origin_nxt       = r_origin;
    w_dl_detect_in_nxt = r_dl_detect_in;
    w_found_nxt        = r_found;
    w_origin_vec_nxt   = '0;
    w_token_clear_nxt  = 1'b0;
    w_valid_nxt        = r_valid;
    w_last_nxt         = r_last;
    w_error_nxt        = r_error;
    w_proc_id_nxt      = r_proc_id;
    w_chan_id_nxt      = r_chan_id;
    w_timeout_nxt      = r_timeout;
    w_pushed_nxt       = r_pushed;
    w_zero_seen_nxt    = r_zero_seen;
    w_push             = 1'b0;
    w_load             = 1'b0;
    w_fifo_clr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.dl_detect_vec != '0) begin
          w_origin_nxt       = w_det_idx;
          w_proc_id_nxt      = w_det_idx;
          w_dl_detect_in_nxt = 1'b1;
          w_found_nxt        = 1'b1;
          w_origin_vec_nxt   = PROC_NUM'(1) << w_det_idx;
          w_state_nxt        = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: begin
        w_fifo_clr      = 1'b1;
        w_timeout_nxt   = '0;
        w_pushed_nxt    = 1'b0;
        w_zero_seen_nxt = 1'b0;
        w_state_nxt     = S_TRACE;
      end
      S_TRACE: begin
        w_timeout_nxt = r_timeout + TO_W'(1);
        if (bus.token_vec != '0) begin
          w_push          = (r_count != CNT_W'(CHAN_NUM));
          w_pushed_nxt    = 1'b1;
          w_zero_seen_nxt = 1'b0;
        end else begin
          w_zero_seen_nxt = r_pushed;
        end
        // A return wins over a simultaneous abort.
        if (w_return) begin
          w_token_clear_nxt = 1'b1;
          w_state_nxt       = S_CLEAR;
        end else if (w_abort) begin
          w_error_nxt       = 1'b1;
          w_token_clear_nxt = 1'b1;
          w_state_nxt       = S_CLEAR;
        end else begin
          w_state_nxt = S_TRACE;
        end
      end
      S_CLEAR: begin
        w_valid_nxt = 1'b1;
        w_state_nxt = S_REPORT;
        if (r_count != '0) begin
          w_load        = 1'b1;
          w_chan_id_nxt = w_head;
          w_last_nxt    = (r_count == CNT_W'(1));
        end else begin
          w_chan_id_nxt = w_det_idx_ext;
          w_last_nxt    = 1'b1;
          w_error_nxt   = 1'b1;
        end
      end
      S_REPORT: begin
        if (r_valid && bus.report_ready) begin
          if (r_last) begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_load        = 1'b1;
            w_chan_id_nxt = w_head;
            w_last_nxt    = (r_count == CNT_W'(1));
            w_state_nxt   = S_REPORT;
          end
        end else begin
          w_state_nxt = S_REPORT;
        end
      end
      S_DONE: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered outputs and trace bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_origin       <= '0;
      r_dl_detect_in <= 1'b0;
      r_found        <= 1'b0;
      r_origin_vec   <= '0;
      r_token_clear  <= 1'b0;
      r_valid        <= 1'b0;
      r_last         <= 1'b0;
      r_error        <= 1'b0;
      r_proc_id      <= '0;
      r_chan_id      <= '0;
      r_timeout      <= '0;
      r_pushed       <= 1'b0;
      r_zero_seen    <= 1'b0;
    end else begin
      r_origin       <= w_origin_nxt;
      r_dl_detect_in <= w_dl_detect_in_nxt;
      r_found        <= w_found_nxt;
      r_origin_vec   <= w_origin_vec_nxt;
      r_token_clear  <= w_token_clear_nxt;
      r_valid        <= w_valid_nxt;
      r_last         <= w_last_nxt;
      r_error        <= w_error_nxt;
      r_proc_id      <= w_proc_id_nxt;
      r_chan_id      <= w_chan_id_nxt;
      r_timeout      <= w_timeout_nxt;
      r_pushed       <= w_pushed_nxt;
      r_zero_seen    <= w_zero_seen_nxt;
    end
  end

  // Path FIFO; an entry leaves the FIFO when it is loaded into the report registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < CHAN_NUM; i++) r_fifo[i] <= '0;
    end else if (w_fifo_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_token_idx;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_load) r_rd_ptr <= ptr_inc(r_rd_ptr);
      else        r_rd_ptr <= r_rd_ptr;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.dl_detect_in   = r_dl_detect_in;
  assign bus.origin_vec     = r_origin_vec;
  assign bus.token_clear    = r_token_clear;
  assign bus.report_valid   = r_valid;
  assign bus.report_proc_id = r_proc_id;
  assign bus.report_chan_id = r_chan_id;
  assign bus.report_last    = r_last;
  assign bus.report_error   = r_error;
  assign bus.deadlock_found = r_found;
endmodule

// File: doc/add_image_hls_deadlock_report_unit.md
# add_image_hls_deadlock_report_unit

Collects the per-process deadlock flags and channel tokens from all `add_image_hls_deadlock_detect_unit` instances in the dataflow region. It arbitrates the first detected deadlock and launches a token from the originating process. It traces the token around the wait-for cycle and records each channel it crosses. It then drains the recorded cycle as a valid/ready report stream to the debug/AXI-lite capture logic, and holds a sticky `deadlock_found` flag.

## Interface
- `PROC_NUM`, 4: number of dataflow processes and detect units.
- `CHAN_NUM`, 8: total dependence channels; width of the flattened token vector.
- `PROC_ID_W`, 2: width of a process index; must satisfy 2^PROC_ID_W >= PROC_NUM.
- `CHAN_ID_W`, 3: width of a channel index; must satisfy 2^CHAN_ID_W >= CHAN_NUM.

- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `dl_detect_vec`  in  PROC_NUM: `dl_detect_out` from each detect unit.
- `token_vec`  in  CHAN_NUM: OR of all units' `token_out_vec`, indexed by global channel id.
- `dl_detect_in`  out  1: broadcast to all units; registered.
- `origin_vec`  out  PROC_NUM: one-hot `origin` strobe per unit.
- `token_clear`  out  1: broadcast to all units; single-cycle strobe.
- `report_valid`  out  1: report entry available.
- `report_ready`  in  1: consumer accepts the entry.
- `report_proc_id`  out  PROC_ID_W: origin process of the cycle; constant during a report.
- `report_chan_id`  out  CHAN_ID_W: channel of the current entry.
- `report_last`  out  1: current entry is the final one.
- `report_error`  out  1: trace aborted (token lost or timeout); sticky.
- `deadlock_found`  out  1: sticky deadlock flag.

## Operation
- The FSM has the states IDLE, LAUNCH, TRACE, CLEAR, REPORT and DONE.
- **IDLE**
  - On any bit of `dl_detect_vec`, latch `origin` as the lowest-index set bit.
  - Set `dl_detect_in` = 1; it is sticky until reset.
  - Set `deadlock_found` = 1.
  - Go to LAUNCH.
- **LAUNCH**
  - Drive `origin_vec` = 1 << origin for exactly one cycle.
  - Clear the trace FIFO and the timeout counter.
  - Go to TRACE.
- **TRACE**
  - On each cycle with `token_vec` != 0, push the lowest set index into the path FIFO (depth CHAN_NUM).
  - Ignore pushes while the FIFO is full; the timeout below bounds this case.
  - If `dl_detect_vec[origin]` = 1, the token has returned: go to CLEAR.
  - If `token_vec` == 0 for 2 consecutive cycles after the first push, set `report_error` and go to CLEAR.
  - If the timeout counter reaches CHAN_NUM+4 cycles, set `report_error` and go to CLEAR.
  - A return and an abort condition in the same cycle count as a return; `report_error` stays 0.
- **CLEAR**
  - Drive `token_clear` = 1 for one cycle.
  - Go to REPORT.
- **REPORT**
  - `report_valid` = 1 when the FIFO is non-empty.
  - On each cycle with valid && ready, pop one entry.
  - `report_last` = 1 when exactly one entry remains.
  - After the last pop, go to DONE.
  - If the FIFO is empty on entry, emit a single entry: `report_chan_id` = 0, `report_last` = 1, `report_error` = 1.
- **DONE**
  - Terminal state until reset.
  - Further `dl_detect_vec` activity is ignored.
  - All strobes stay at 0.
- Only one deadlock is reported per reset.
- A reset asserted mid-trace or mid-report returns the block to IDLE immediately.

## Timing
- Reset values:
  - `dl_detect_in`, `origin_vec`, `token_clear`, `report_valid`, `report_last`, `report_error`, `deadlock_found` = 0.
  - `report_proc_id`, `report_chan_id` = 0.
  - State = IDLE; FIFO empty.
- Detection at cycle t (IDLE): `dl_detect_in` and `deadlock_found` high from t+1.
- `origin_vec` is high during t+1 only.
- TRACE is entered at t+2. The first token is expected at t+2, because the unit registers `token_out` on the LAUNCH edge.
- `token_clear` is high for exactly the one cycle after the return is observed.
- The first `report_valid` appears the cycle after CLEAR.
- Report handshake:
  - `report_chan_id`, `report_last` and `report_proc_id` are stable while valid && !ready.
  - `report_valid` never drops without a transfer.
  - Throughput is one entry per cycle when `report_ready` = 1.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Ring P0->P1->P2->P0 on channels 2, 5, 7, with `report_ready` held at 1:
  - `dl_detect_vec` = 0001 at t.
  - Required: `origin_vec` = 0001 at t+1.
  - Required: entries 2, 5, 7 with `report_proc_id` = 0 and `report_last` on 7.
  - Required: `token_clear` pulses once; `report_error` = 0.
- Simultaneous `dl_detect_vec` = 1010 → origin = 1 and `origin_vec` = 0010; P3 is ignored.
- Token vanishes after channel 3 (`token_vec` = 0 for 2 cycles):
  - Required: `report_error` = 1.
  - Required: one entry 3 with `report_last` = 1.
  - Required: `token_clear` pulsed.
- Backpressure during a 3-entry report: `report_ready` toggles 0,0,1,0,1,1.
  - Required: each entry is held stable while stalled.
  - Required: exactly 3 transfers in order, and no dropped or repeated entries.
- Reset pulled low while in TRACE with 2 entries queued:
  - Required: all outputs return to 0 asynchronously.
  - Required: a new detection after reset restarts at LAUNCH with an empty FIFO.
- Token never returns (token circulates without `dl_detect_vec[origin]`):
  - Required: timeout after 12 cycles (CHAN_NUM = 8).
  - Required: `report_error` = 1, and at most 8 entries reported.
